bcd_scan_display: RTL and testbench
===================================

# bcd_scan_display

Display back-end of the calculator: takes the 14-bit binary number selected for display and drives a 4-digit, common-anode, multiplexed 7-segment display. A multi-cycle double-dabble converter turns the binary value into four BCD digits. A refresh counter then scans the digits with leading-zero blanking, and values above 9999 show an overflow pattern. It sits directly downstream of the display-number multiplexer in the calculator top level.

## Interface
- `REFRESH_OVERFLOW`, default 2**19-1: refresh counter terminal count; the digit advances once per `REFRESH_OVERFLOW+1` clocks.
- `BLANK_LEADING`, default 1: 1 blanks leading zeros; 0 shows all four digits.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `to_display_nr` in 14: unsigned binary value to show, 0..16383.
- `digit_select` out 4: active-low anode enables; bit0 is the rightmost (units) digit.
- `led_select` out 7: active-low segments {g,f,e,d,c,b,a}; bit0 = a.
- `busy` out 1: high while a conversion is in progress.

## Operation
- **Reset values**
  - bcd display register = 0000; last_value = 0; FSM = IDLE; refresh counter = 0; digit index = 0.
  - `digit_select`=4'b1110, `led_select`=7'b1000000 ("0"), `busy`=0.
- **FSM states: IDLE, SHIFT, COMMIT.**
  - IDLE: if `to_display_nr` != last_value, capture it into the shift register and into last_value, clear BCD accumulators, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: 14 double-dabble iterations, one per clock. In each iteration, add 3 to any nibble ≥5, then shift left by 1. A 4-bit iteration counter runs 0..13. After iteration 13, go to COMMIT.
  - COMMIT: write the 4 BCD nibbles and an overflow flag (last_value > 9999) into the display register, then go to IDLE.
- `busy` is high in SHIFT and COMMIT.
- **Input changes during SHIFT/COMMIT** are ignored. Because the compare is against last_value, the newest value is converted on the next IDLE cycle. No value is ever partially displayed.
- **Overflow** (> 9999): every enabled digit shows "-" (7'b0111111). Blanking does not apply.
- **Leading-zero blanking**, when `BLANK_LEADING`=1:
  - Digit k (k ≥ 1) is blank (7'b1111111) if it and all higher digits are 0.
  - Digit 0 is never blank.
  - Blanked digits keep their anode enabled and show segments off.
- **Scan**
  - The refresh counter increments every clock.
  - When it equals `REFRESH_OVERFLOW`, it wraps to 0 and the digit index advances 0→1→2→3→0.
  - `digit_select` is the one-cold decode of the digit index.
- BCD width rule: each nibble saturates logically at 9. Bits above the 4 digits do not exist, since 14-bit inputs above 9999 go through the overflow path.

## Timing
- **Conversion latency**
  - A new value sampled in IDLE at edge t updates the display register at edge t+15 (1 capture, 14 shifts minus overlap, 1 commit).
  - `led_select` reflects the new register at edge t+16.
- `digit_select` and `led_select` are both registered and change on the same edge. There is no cycle where an anode is paired with another digit's segments.
- **Digit dwell**: `REFRESH_OVERFLOW`+1 clocks per digit. Full frame: 4×(`REFRESH_OVERFLOW`+1).
- **Back-to-back changes**: at most one conversion every 16 clocks. Intermediate values may be skipped; the final stable value is always shown within 32 clocks of becoming stable.
- **reset_n assertion mid-conversion**: aborts immediately and forces all reset values asynchronously. After release, the first edge is IDLE and a nonzero input starts a conversion.

## Structure
- **Package `calc_display_pkg`**:
  - FSM state enum (IDLE/SHIFT/COMMIT).
  - Segment constants SEG_BLANK, SEG_DASH.
  - Function seg_decode(nibble) → 7-bit active-low pattern for 0-9.
- **Sub-module `bin2bcd_iter`**: the double-dabble datapath and iteration counter, with a start/done interface.
- The top holds the FSM, display register, refresh counter, blanking logic and output registers.

## Test plan
Benches use `REFRESH_OVERFLOW`=3.
- **Reset**: hold reset_n=0 with input 1234 → `digit_select`=1110, `led_select`=1000000, `busy`=0. After release, `busy` rises the next edge and 1234 is shown after 16 clocks.
- **Scan**: input 1234 converted → digits 0..3 show 4,3,2,1 (7'b0011001, 0110000, 0100100, 1111001). Each dwells 4 clocks with the matching one-cold anode.
- **Blanking**: input 7 → digits 1-3 show 1111111 and digit 0 shows 1111000. With `BLANK_LEADING`=0, digits 1-3 show 1000000.
- **Overflow**: input 10000 and 16383 → all four digits 0111111. Input 9999 → four "9" (0010000).
- **Mid-conversion change**: 0→42, then 42→9000 three clocks later → 42 is committed, then 9000 is committed ≤16 clocks after that. No other value appears.
- **Async reset during SHIFT**: assert reset_n between edges → outputs take their reset values before the next edge. `busy`=0 and the display shows "0".

Source files
------------

// File: rtl/calc_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_display_pkg
// Description : Shared types and constants for the calculator display
//               back-end: converter FSM states, widths and the active-low
//               7-segment encoding {g,f,e,d,c,b,a}.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_display_pkg;

  // Converter control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam int c_BIN_W      = 14;
  localparam int c_BCD_W      = 16;
  localparam int c_ITERATIONS = 14;

  // Largest value that fits in four decimal digits
  localparam logic [c_BIN_W-1:0] c_MAX_SHOWN = 14'd9999;

  // Active-low segment patterns, bit0 = segment a
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Decimal digit to active-low segment pattern; non-decimal codes go dark
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_scan_display_bin2bcd_iter.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_iter
// Description : Sequential double-dabble converter. A start pulse loads the
//               binary value and clears the BCD accumulators; each shift_en
//               cycle then performs one add-3/shift iteration. done marks the
//               cycle whose edge completes the final iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_iter
  import calc_display_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 shift_en,
  input  logic [c_BIN_W-1:0]   bin,
  output logic [c_BCD_W-1:0]   bcd,
  output logic                 done
);

  logic [c_BIN_W-1:0] r_bin;
  logic [c_BCD_W-1:0] r_bcd;
  logic [3:0]         r_cnt;
  logic [c_BCD_W-1:0] w_adj;

  // Add 3 to every nibble that would exceed 9 after doubling
  generate
    for (genvar g = 0; g < 4; g++) begin : g_nibble
      assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? (r_bcd[4*g +: 4] + 4'd3)
                                                          : r_bcd[4*g +: 4];
    end
  endgenerate

  // Load on start, otherwise shift the adjusted accumulator with the binary value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_bin <= bin;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (shift_en) begin
      {r_bcd, r_bin} <= {w_adj[c_BCD_W-2:0], r_bin, 1'b0};
      r_cnt          <= r_cnt + 4'd1;
    end
  end

  assign done = shift_en && (r_cnt == 4'(c_ITERATIONS - 1));
  assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : bcd_scan_display
// Description : 4-digit multiplexed common-anode 7-segment driver. Converts a
//               14-bit value to BCD in the background, commits it atomically,
//               and scans the digits with leading-zero blanking and an
//               all-dash pattern for values above 9999.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_scan_display
  import calc_display_pkg::*;
#(
  parameter int REFRESH_OVERFLOW = 2**19 - 1,
  parameter int BLANK_LEADING    = 1
)
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [c_BIN_W-1:0] to_display_nr,
  output logic [3:0]         digit_select,
  output logic [6:0]         led_select,
  output logic               busy
);

  localparam int c_CNT_W = (REFRESH_OVERFLOW > 0) ? $clog2(REFRESH_OVERFLOW + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_TC = c_CNT_W'(REFRESH_OVERFLOW);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_start;
  logic               w_shift_en;
  logic               w_conv_done;
  logic [c_BCD_W-1:0] w_conv_bcd;

  logic [c_BIN_W-1:0] r_last_value;
  logic [c_BCD_W-1:0] r_disp_bcd;
  logic               r_disp_ovf;

  logic [c_CNT_W-1:0] r_refresh;
  logic [1:0]         r_digit_idx;
  logic [1:0]         w_idx_next;
  logic               w_wrap;

  logic [3:0]         w_nibble;
  logic               w_upper_zero;
  logic               w_blank;
  logic [6:0]         w_seg_next;
  logic [3:0]         w_sel_next;

  logic [3:0]         r_digit_select;
  logic [6:0]         r_led_select;

  bin2bcd_iter u_bin2bcd (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (w_start),
    .shift_en (w_shift_en),
    .bin      (to_display_nr),
    .bcd      (w_conv_bcd),
    .done     (w_conv_done)
  );

  // Converter state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next state and converter controls; input changes are only seen in IDLE
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_shift_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (to_display_nr != r_last_value) begin
          w_start      = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift_en = 1'b1;
        if (w_conv_done) w_state_next = ST_COMMIT;
      end
      ST_COMMIT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Remember the value being converted; publish the finished result in one step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_value <= '0;
      r_disp_bcd   <= '0;
      r_disp_ovf   <= 1'b0;
    end else begin
      if (w_start) r_last_value <= to_display_nr;
      if (r_state == ST_COMMIT) begin
        r_disp_bcd <= w_conv_bcd;
        r_disp_ovf <= (r_last_value > c_MAX_SHOWN);
      end
    end
  end

  assign w_wrap     = (r_refresh == c_CNT_TC);
  assign w_idx_next = w_wrap ? (r_digit_idx + 2'd1) : r_digit_idx;

  // Refresh prescaler and digit index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_refresh   <= '0;
      r_digit_idx <= 2'd0;
    end else begin
      r_refresh   <= w_wrap ? '0 : (r_refresh + c_CNT_W'(1));
      r_digit_idx <= w_idx_next;
    end
  end

  // Segment pattern for the digit that becomes active at the next edge
  always_comb begin
    w_nibble     = r_disp_bcd[{w_idx_next, 2'b00} +: 4];
    w_upper_zero = ((r_disp_bcd >> {w_idx_next, 2'b00}) == '0);
    w_blank      = (BLANK_LEADING != 0) && (w_idx_next != 2'd0) && w_upper_zero;
    w_sel_next   = ~(4'b0001 << w_idx_next);
    if (r_disp_ovf)   w_seg_next = SEG_DASH;
    else if (w_blank) w_seg_next = SEG_BLANK;
    else              w_seg_next = seg_decode(w_nibble);
  end

  // Anode and segments registered together so they always switch on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_digit_select <= 4'b1110;
      r_led_select   <= seg_decode(4'd0);
    end else begin
      r_digit_select <= w_sel_next;
      r_led_select   <= w_seg_next;
    end
  end

  assign digit_select = r_digit_select;
  assign led_select   = r_led_select;
  assign busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_scan_display
// Description : Self-checking bench for bcd_scan_display with a refresh
//               terminal count of 3; one instance blanks leading zeros, the
//               other shows all digits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_display;

  localparam int RO = 3;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0010000;
  localparam logic [6:0] PB = 7'b1111111;
  localparam logic [6:0] PD = 7'b0111111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [13:0] to_display_nr = 14'd0;
  logic [3:0]  dsel_a, dsel_b;
  logic [6:0]  led_a, led_b;
  logic        busy_a, busy_b;

  always #5 clk = ~clk;

  bcd_scan_display #(.REFRESH_OVERFLOW(RO), .BLANK_LEADING(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .to_display_nr(to_display_nr),
    .digit_select(dsel_a), .led_select(led_a), .busy(busy_a));

  bcd_scan_display #(.REFRESH_OVERFLOW(RO), .BLANK_LEADING(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .to_display_nr(to_display_nr),
    .digit_select(dsel_b), .led_select(led_b), .busy(busy_b));

  typedef struct {
    logic [3:0] sel;
    logic [6:0] seg_a;
    logic [6:0] seg_b;
  } exp_t;

  typedef struct {
    int              value;
    logic [3:0][6:0] a;
    logic [3:0][6:0] b;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];
  int   total = 0;
  int   bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference pattern for digit k of value v
  function automatic logic [6:0] exp_seg(input int v, input int k, input bit blank);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (v > 9999) return PD;
    if (blank && k >= 1 && v < p) return PB;
    return seg_of((v / p) % 10);
  endfunction

  function automatic int idx_of(input logic [3:0] sel);
    case (sel)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic push_frame(input logic [3:0][6:0] a, input logic [3:0][6:0] b);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.sel   = ~(4'b0001 << k);
      e.seg_a = a[k];
      e.seg_b = b[k];
      sb_q.push_back(e);
    end
  endtask

  task automatic push_model(input int v);
    logic [3:0][6:0] a;
    logic [3:0][6:0] b;
    for (int k = 0; k < 4; k++) begin
      a[k] = exp_seg(v, k, 1'b1);
      b[k] = exp_seg(v, k, 1'b0);
    end
    push_frame(a, b);
  endtask

  // Align to the start of a scan frame, then pop and check four digit dwells
  task automatic check_frame(input string tag);
    logic [3:0] prev;
    bit         found;
    exp_t       e;
    found = 1'b0;
    prev  = dsel_b;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (dsel_b == 4'b1110 && prev == 4'b0111) found = 1'b1;
      else prev = dsel_b;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s frame_sync: got no scan start want start within 40 clocks", tag);
      while (sb_q.size() > 0) e = sb_q.pop_front();
      return;
    end
    for (int k = 0; k < 4; k++) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s scoreboard: got empty queue want entry", tag);
        return;
      end
      e = sb_q.pop_front();
      for (int j = 0; j < 4; j++) begin
        check($sformatf("%s d%0d c%0d sel_a", tag, k, j), 32'(dsel_a), 32'(e.sel));
        check($sformatf("%s d%0d c%0d sel_b", tag, k, j), 32'(dsel_b), 32'(e.sel));
        check($sformatf("%s d%0d c%0d seg_a", tag, k, j), 32'(led_a), 32'(e.seg_a));
        check($sformatf("%s d%0d c%0d seg_b", tag, k, j), 32'(led_b), 32'(e.seg_b));
        tick();
      end
    end
  endtask

  initial begin
    int  k;
    int  val;
    bit  exp_busy;

    vecs[0] = '{7,     {PB, PB, PB, P7}, {P0, P0, P0, P7}};
    vecs[1] = '{105,   {PB, P1, P0, P5}, {P0, P1, P0, P5}};
    vecs[2] = '{8060,  {P8, P0, P6, P0}, {P8, P0, P6, P0}};
    vecs[3] = '{9999,  {P9, P9, P9, P9}, {P9, P9, P9, P9}};
    vecs[4] = '{10000, {PD, PD, PD, PD}, {PD, PD, PD, PD}};
    vecs[5] = '{16383, {PD, PD, PD, PD}, {PD, PD, PD, PD}};
    vecs[6] = '{0,     {PB, PB, PB, P0}, {P0, P0, P0, P0}};

    // Reset held with a nonzero input
    to_display_nr = 14'd1234;
    #2 reset_n = 1'b0;
    repeat (3) tick();
    check("rst sel_a",  32'(dsel_a), 32'(4'b1110));
    check("rst seg_a",  32'(led_a),  32'(P0));
    check("rst busy_a", 32'(busy_a), 32'd0);
    check("rst sel_b",  32'(dsel_b), 32'(4'b1110));
    check("rst seg_b",  32'(led_b),  32'(P0));
    check("rst busy_b", 32'(busy_b), 32'd0);

    // Release: conversion starts on the first edge, result visible 16 edges later
    reset_n = 1'b1;
    push_model(1234);
    tick();
    check("rel busy n1", 32'(busy_a), 32'd1);
    repeat (14) tick();
    check("rel busy n15", 32'(busy_a), 32'd1);
    tick();
    check("rel busy n16", 32'(busy_a), 32'd0);
    check("rel seg n16 old", 32'(led_a), 32'(P0));
    check("rel sel n16", 32'(dsel_a), 32'(4'b1110));
    tick();
    check("rel seg n17 new", 32'(led_a), 32'(P4));
    check("rel sel n17", 32'(dsel_a), 32'(4'b1110));
    check_frame("rst_1234");

    // Table-driven values
    for (int i = 0; i < 7; i++) begin
      to_display_nr = 14'(vecs[i].value);
      push_frame(vecs[i].a, vecs[i].b);
      repeat (17) tick();
      check_frame($sformatf("vec%0d_%0d", i, vecs[i].value));
    end

    // Change during conversion: 0 -> 42, then 9000 three clocks later
    to_display_nr = 14'd42;
    tick();
    check("mid busy n1", 32'(busy_a), 32'd1);
    tick();
    tick();
    to_display_nr = 14'd9000;
    for (int n = 4; n <= 45; n++) begin
      tick();
      exp_busy = (n <= 15) || (n >= 17 && n <= 31);
      val = (n <= 16) ? 0 : ((n <= 32) ? 42 : 9000);
      check($sformatf("mid busy n%0d", n), 32'(busy_a), 32'(exp_busy));
      k = idx_of(dsel_b);
      if (k < 0) begin
        total++;
        bad++;
        $display("FAIL mid sel n%0d: got %0b want one-cold", n, dsel_b);
      end else begin
        check($sformatf("mid seg_a n%0d", n), 32'(led_a), 32'(exp_seg(val, k, 1'b1)));
        check($sformatf("mid seg_b n%0d", n), 32'(led_b), 32'(exp_seg(val, k, 1'b0)));
      end
    end

    // Asynchronous reset in the middle of a conversion
    to_display_nr = 14'd1234;
    push_model(1234);
    repeat (5) tick();
    check("arst busy before", 32'(busy_a), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst sel_a",  32'(dsel_a), 32'(4'b1110));
    check("arst seg_a",  32'(led_a),  32'(P0));
    check("arst seg_b",  32'(led_b),  32'(P0));
    check("arst busy_a", 32'(busy_a), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("arst busy restart", 32'(busy_a), 32'd1);
    repeat (17) tick();
    check_frame("arst_1234");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
